// File: rtl/decoder_n_seq.sv
// Registered N-to-2^N one-hot decoder with DIRECT and SWEEP modes.
// Optional sel parity checking: define DECODER_N_SEQ_PARITY_EN.
module decoder_n_seq #(
    parameter int N       = 2,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       sel,
    input  logic               sel_par,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    Y,
    output logic               out_valid,
    output logic               busy,
    output logic               err
);

    localparam int W = 2**N;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t             state, state_n;
    logic [W-1:0]       y_n;
    logic               ov_n;
    logic [N-1:0]       ptr, ptr_n;
    logic [N-1:0]       steps, steps_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] dw, dw_n;
    logic               accept;
    logic               bad;
    logic               drop;

    assign in_ready = en && (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == SWEEP);

`ifdef DECODER_N_SEQ_PARITY_EN
    assign bad = ^{sel, sel_par};
`else
    logic unused_par;
    assign unused_par = sel_par;
    assign bad        = 1'b0;
`endif

    // A bad-parity request still completes the handshake, then vanishes
    assign drop = accept && bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            Y         <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            steps     <= '0;
            cnt       <= '0;
            dw        <= '0;
        end else begin
            state     <= state_n;
            Y         <= y_n;
            out_valid <= ov_n;
            ptr       <= ptr_n;
            steps     <= steps_n;
            cnt       <= cnt_n;
            dw        <= dw_n;
        end
    end

    always_comb begin
        state_n = state;
        y_n     = Y;
        ov_n    = 1'b0;
        ptr_n   = ptr;
        steps_n = steps;
        cnt_n   = cnt;
        dw_n    = dw;
        if (!en) begin
            state_n = IDLE;
            y_n     = '0;
            ptr_n   = '0;
            steps_n = '0;
            cnt_n   = '0;
            dw_n    = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && !drop) begin
                        y_n  = W'(1) << sel;
                        ov_n = 1'b1;
                        if (mode) begin
                            state_n = SWEEP;
                            ptr_n   = sel;
                            dw_n    = dwell;
                            cnt_n   = '0;
                            steps_n = '0;
                        end
                    end
                end
                SWEEP: begin
                    if (cnt == dw) begin
                        cnt_n = '0;
                        // steps counts codes already finished; all-ones means the last one
                        if (steps == {N{1'b1}}) begin
                            state_n = IDLE;
                            y_n     = '0;
                            ptr_n   = '0;
                            steps_n = '0;
                            dw_n    = '0;
                        end else begin
                            ptr_n   = ptr + N'(1);
                            steps_n = steps + N'(1);
                            y_n     = W'(1) << ptr_n;
                            ov_n    = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + DWELL_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef DECODER_N_SEQ_PARITY_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (drop) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_n_seq.sv
// Directed bench for decoder_n_seq with an out_valid scoreboard.
// Parity steps follow DECODER_N_SEQ_PARITY_EN.
module tb_decoder_n_seq;

    localparam int N  = 2;
    localparam int DW = 4;
    localparam int W  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  sel;
    logic          sel_par;
    logic [DW-1:0] dwell;
    logic [W-1:0]  Y;
    logic          out_valid;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] sbq[$];
    logic [W-1:0] exp_y;

    always #5 clk = ~clk;

    decoder_n_seq #(.N(N), .DWELL_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .sel_par  (sel_par),
        .dwell    (dwell),
        .Y        (Y),
        .out_valid(out_valid),
        .busy     (busy),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic m, input logic [N-1:0] s,
                       input logic [DW-1:0] d);
        mode     = m;
        sel      = s;
        sel_par  = ^s;
        dwell    = d;
        in_valid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("onehot", 32'($countones(Y) <= 1), 1);
            if (out_valid === 1'b1) begin
                chk("sb_depth", 32'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    exp_y = sbq.pop_front();
                    chk("sb_Y", 32'(Y), 32'(exp_y));
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b0;
        sel      = '0;
        sel_par  = 1'b0;
        dwell    = '0;
        repeat (2) cyc();
        chk("rst_Y", 32'(Y), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        en  = 1'b1;
        #1;
        chk("rel_ready", 32'(in_ready), 1);

        // direct decode
        req(1'b0, 2'd2, 4'd0);
        sbq.push_back(4'b0100);
        #1 chk("d1_ready", 32'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        chk("d1_Y", 32'(Y), 32'h4);
        chk("d1_ov", 32'(out_valid), 1);
        cyc();
        chk("d1_hold", 32'(Y), 32'h4);
        chk("d1_ov0", 32'(out_valid), 0);

        // sweep from 3 with dwell 1
        req(1'b1, 2'd3, 4'd1);
        for (int i = 0; i < 4; i++) sbq.push_back(W'(1) << ((3 + i) % 4));
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("sw_Y", 32'(Y), 32'(1 << ((3 + i / 2) % 4)));
            chk("sw_busy", 32'(busy), 1);
            chk("sw_ov", 32'(out_valid), 32'(i % 2 == 0));
            chk("sw_ready", 32'(in_ready), 0);
            cyc();
        end
        chk("sw_end_Y", 32'(Y), 0);
        chk("sw_end_busy", 32'(busy), 0);
        chk("sw_end_ov", 32'(out_valid), 0);
        chk("sw_end_ready", 32'(in_ready), 1);

        // en=0 aborts a sweep
        req(1'b1, 2'd1, 4'd2);
        sbq.push_back(4'b0010);
        cyc();
        in_valid = 1'b0;
        chk("ab_busy", 32'(busy), 1);
        cyc();
        en = 1'b0;
        #1 chk("ab_ready", 32'(in_ready), 0);
        cyc();
        chk("ab_Y", 32'(Y), 0);
        chk("ab_busy0", 32'(busy), 0);
        chk("ab_ov", 32'(out_valid), 0);
        en = 1'b1;
        req(1'b0, 2'd0, 4'd0);
        sbq.push_back(4'b0001);
        #1 chk("ab_ready1", 32'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        chk("ab_d_Y", 32'(Y), 32'h1);
        chk("ab_d_ov", 32'(out_valid), 1);

        // asynchronous reset mid-sweep
        req(1'b1, 2'd0, 4'd3);
        sbq.push_back(4'b0001);
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("rs_pre_busy", 32'(busy), 1);
        chk("rs_pre_Y", 32'(Y), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rs_Y", 32'(Y), 0);
        chk("rs_ov", 32'(out_valid), 0);
        chk("rs_busy", 32'(busy), 0);
        rst = 1'b0;
        #1 chk("rs_ready", 32'(in_ready), 1);

        // request held while busy, dwell 0
        cyc();
        req(1'b1, 2'd2, 4'd0);
        for (int i = 0; i < 4; i++) sbq.push_back(W'(1) << ((2 + i) % 4));
        cyc();
        mode    = 1'b0;
        sel     = 2'd1;
        sel_par = 1'b1;
        sbq.push_back(4'b0010);
        for (int i = 0; i < 4; i++) begin
            chk("hv_Y", 32'(Y), 32'(1 << ((2 + i) % 4)));
            chk("hv_ov", 32'(out_valid), 1);
            chk("hv_busy", 32'(busy), 1);
            chk("hv_ready", 32'(in_ready), 0);
            cyc();
        end
        chk("hv_idle_Y", 32'(Y), 0);
        chk("hv_idle_ready", 32'(in_ready), 1);
        chk("hv_idle_busy", 32'(busy), 0);
        cyc();
        in_valid = 1'b0;
        chk("hv_d_Y", 32'(Y), 32'h2);
        chk("hv_d_ov", 32'(out_valid), 1);

        // parity handling
        req(1'b0, 2'd3, 4'd0);
        sbq.push_back(4'b1000);
        cyc();
        in_valid = 1'b0;
        chk("par_good_Y", 32'(Y), 32'h8);
        req(1'b0, 2'd1, 4'd0);
        sel_par = 1'b0;
`ifdef DECODER_N_SEQ_PARITY_EN
        #1 chk("par_bad_ready", 32'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        chk("par_bad_Y", 32'(Y), 32'h8);
        chk("par_bad_ov", 32'(out_valid), 0);
        chk("par_err", 32'(err), 1);
        cyc();
        chk("par_err_sticky", 32'(err), 1);
        chk("par_Y_keep", 32'(Y), 32'h8);
        req(1'b0, 2'd1, 4'd0);
        sbq.push_back(4'b0010);
        cyc();
        in_valid = 1'b0;
        chk("par_fix_Y", 32'(Y), 32'h2);
        chk("par_fix_ov", 32'(out_valid), 1);
        chk("par_fix_err", 32'(err), 1);
`else
        sbq.push_back(4'b0010);
        cyc();
        in_valid = 1'b0;
        chk("nopar_Y", 32'(Y), 32'h2);
        chk("nopar_ov", 32'(out_valid), 1);
        chk("nopar_err", 32'(err), 0);
`endif

        // en=0 blocks a pending request
        en = 1'b0;
        req(1'b0, 2'd3, 4'd0);
        #1 chk("off_ready", 32'(in_ready), 0);
        cyc();
        chk("off_Y", 32'(Y), 0);
        chk("off_ov", 32'(out_valid), 0);
        cyc();
        chk("off_Y2", 32'(Y), 0);
        in_valid = 1'b0;
        en       = 1'b1;

        cyc();
        chk("sb_left", 32'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
